// File: rtl/mem_pkg.sv
// Shared definitions for the data-cache port arbiter: FSM state encoding
// and lane index constants used by the top and the request mux.
package mem_pkg;

   // Arbiter states (two-bit legacy-compatible encoding)
   localparam logic [1:0] IDLE = 2'd0;   // waiting for an M-stage group
   localparam logic [1:0] L0   = 2'd1;   // lane 0 access outstanding
   localparam logic [1:0] L1   = 2'd2;   // lane 1 access outstanding
   localparam logic [1:0] DONE = 2'd3;   // group finished, pipeline advances

   // Lane indices
   localparam logic LANE_0 = 1'b0;
   localparam logic LANE_1 = 1'b1;
   localparam int   NUM_LANES = 2;

   // State owning the access of a given lane
   function automatic logic [1:0] lane_state(input int lane);
      return (lane == 0) ? L0 : L1;
   endfunction

endpackage

// File: rtl/mem_req_mux.sv
// Registered selection of one lane's memory request onto the cache port.
// The strobes, address and write data are loaded when an access starts and
// cleared when the group leaves the access states, so the cache only ever
// sees clean registered signals.
module mem_req_mux
   import mem_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          clear,
   input  logic          sel,
   input  logic          we_0,
   input  logic [AW-1:0] addr_0,
   input  logic [DW-1:0] wdata_0,
   input  logic          we_1,
   input  logic [AW-1:0] addr_1,
   input  logic [DW-1:0] wdata_1,
   output logic          cache_re,
   output logic          cache_we,
   output logic [AW-1:0] cache_addr,
   output logic [DW-1:0] cache_wd
);

   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Pick the lane whose request is about to be issued
   always_comb begin
      sel_we    = we_0;
      sel_addr  = addr_0;
      sel_wdata = wdata_0;
      if (sel == LANE_1) begin
         sel_we    = we_1;
         sel_addr  = addr_1;
         sel_wdata = wdata_1;
      end
   end

   // Cache request registers: load wins over clear so L0 -> L1 hands over directly
   always_ff @(posedge clk) begin
      if (!reset) begin
         cache_re   <= 1'b0;
         cache_we   <= 1'b0;
         cache_addr <= '0;
         cache_wd   <= '0;
      end else if (load) begin
         cache_re   <= ~sel_we;
         cache_we   <= sel_we;
         cache_addr <= sel_addr;
         cache_wd   <= sel_wdata;
      end else if (clear) begin
         cache_re   <= 1'b0;
         cache_we   <= 1'b0;
         cache_addr <= '0;
         cache_wd   <= '0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the memory ops of a dual-issue M-stage group onto the single
// data-cache port: lane 0 first, then lane 1. Stalls the pipeline until the
// group is serviced, captures load data per lane, watches for a cache that
// never answers and counts groups that carried two memory ops.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_0,
   input  logic             we_0,
   input  logic [AW-1:0]    addr_0,
   input  logic [DW-1:0]    wdata_0,
   input  logic             req_1,
   input  logic             we_1,
   input  logic [AW-1:0]    addr_1,
   input  logic [DW-1:0]    wdata_1,
   output logic             cache_re,
   output logic             cache_we,
   output logic [AW-1:0]    cache_addr,
   output logic [DW-1:0]    cache_wd,
   input  logic [DW-1:0]    cache_rd,
   input  logic             cache_ready,
   output logic [DW-1:0]    rdata_0,
   output logic [DW-1:0]    rdata_1,
   output logic             pipe_stall,
   output logic             err_timeout,
   output logic [CNT_W-1:0] dual_cnt
);

   // Timer wide enough to hold TIMEOUT; it saturates there
   localparam int            TW        = $clog2(TIMEOUT + 1) + 1;
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
   localparam logic [TW-1:0] TIMER_ARM = TW'(TIMEOUT - 1);

   logic [1:0]       state_reg, state_next;
   logic [TW-1:0]    timer_reg;
   logic             err_reg;
   logic [CNT_W-1:0] dual_reg;
   logic             load, clear, sel;
   logic             in_access, waiting;
   logic             stall_raw;
   logic [NUM_LANES-1:0] lane_we;
   logic [DW-1:0]    rdata_arr [NUM_LANES];

   assign lane_we   = {we_1, we_0};
   assign in_access = (state_reg == L0) || (state_reg == L1);
   assign waiting   = in_access && !cache_ready;

   // Next-state and request-mux control
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      clear      = 1'b0;
      sel        = LANE_0;
      case (state_reg)
         IDLE: begin
            if (req_0) begin
               state_next = L0;
               load       = 1'b1;
               sel        = LANE_0;
            end else if (req_1) begin
               state_next = L1;
               load       = 1'b1;
               sel        = LANE_1;
            end
         end
         L0: begin
            if (cache_ready) begin
               if (req_1) begin
                  state_next = L1;
                  load       = 1'b1;
                  sel        = LANE_1;
               end else begin
                  state_next = DONE;
                  clear      = 1'b1;
               end
            end
         end
         L1: begin
            if (cache_ready) begin
               state_next = DONE;
               clear      = 1'b1;
            end
         end
         DONE: begin
            // Requests still belong to the group that just finished
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Stall decode; the pipeline is held in reset too, so no stall is reported then
   always_comb begin
      stall_raw = 1'b0;
      case (state_reg)
         IDLE:    stall_raw = req_0 | req_1;
         L0, L1:  stall_raw = 1'b1;
         default: stall_raw = 1'b0;
      endcase
      pipe_stall = reset & stall_raw;
   end

   // Watchdog timer: restarts with each access, counts cycles without cache_ready
   always_ff @(posedge clk) begin
      if (!reset) begin
         timer_reg <= '0;
      end else if (load) begin
         timer_reg <= '0;
      end else if (waiting && (timer_reg != TIMER_MAX)) begin
         timer_reg <= timer_reg + 1'b1;
      end
   end

   // Sticky timeout flag, set on the edge where the timer reaches TIMEOUT
   always_ff @(posedge clk) begin
      if (!reset) begin
         err_reg <= 1'b0;
      end else if (waiting && (timer_reg >= TIMER_ARM)) begin
         err_reg <= 1'b1;
      end
   end

   // Saturating count of groups in which both lanes had a memory op
   always_ff @(posedge clk) begin
      if (!reset) begin
         dual_reg <= '0;
      end else if ((state_reg == IDLE) && req_0 && req_1 && (dual_reg != '1)) begin
         dual_reg <= dual_reg + 1'b1;
      end
   end

   // Per-lane load result registers, captured only in that lane's access state
   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      localparam logic [1:0] OWN_STATE = lane_state(gi);
      logic [DW-1:0] cap_reg;

      // Capture read data when this lane's load completes
      always_ff @(posedge clk) begin
         if (!reset) begin
            cap_reg <= '0;
         end else if ((state_reg == OWN_STATE) && cache_ready && !lane_we[gi]) begin
            cap_reg <= cache_rd;
         end
      end

      assign rdata_arr[gi] = cap_reg;
   end

   mem_req_mux #(
      .AW (AW),
      .DW (DW)
   ) u_req_mux (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .clear      (clear),
      .sel        (sel),
      .we_0       (we_0),
      .addr_0     (addr_0),
      .wdata_0    (wdata_0),
      .we_1       (we_1),
      .addr_1     (addr_1),
      .wdata_1    (wdata_1),
      .cache_re   (cache_re),
      .cache_we   (cache_we),
      .cache_addr (cache_addr),
      .cache_wd   (cache_wd)
   );

   assign rdata_0     = rdata_arr[0];
   assign rdata_1     = rdata_arr[1];
   assign err_timeout = err_reg;
   assign dual_cnt    = dual_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the driver issues M-stage groups
// and pushes the expected cache accesses and group results; a cache model
// checks each access as it appears and a monitor checks results when the
// group completes.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             req_0 = 1'b0, we_0 = 1'b0, req_1 = 1'b0, we_1 = 1'b0;
   logic [AW-1:0]    addr_0 = '0, addr_1 = '0;
   logic [DW-1:0]    wdata_0 = '0, wdata_1 = '0;
   logic             cache_re, cache_we, cache_ready = 1'b0;
   logic [AW-1:0]    cache_addr;
   logic [DW-1:0]    cache_wd, cache_rd = '0;
   logic [DW-1:0]    rdata_0, rdata_1;
   logic             pipe_stall, err_timeout;
   logic [CNT_W-1:0] dual_cnt;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
      .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
      .cache_re(cache_re), .cache_we(cache_we), .cache_addr(cache_addr),
      .cache_wd(cache_wd), .cache_rd(cache_rd), .cache_ready(cache_ready),
      .rdata_0(rdata_0), .rdata_1(rdata_1), .pipe_stall(pipe_stall),
      .err_timeout(err_timeout), .dual_cnt(dual_cnt)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
   } acc_t;

   typedef struct packed {
      logic [31:0]      r0;
      logic [31:0]      r1;
      logic [CNT_W-1:0] dual;
      logic             err;
   } res_t;

   acc_t acc_q[$];
   res_t res_q[$];
   int   lat_q[$];

   int checks = 0;
   int errors = 0;
   int group_no = 0;
   int acc_count = 0;

   // Reference model state: program-order memory image and lane results
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] ref_r0 = '0, ref_r1 = '0;
   int          ref_dual = 0;
   logic        ref_err = 1'b0;

   // Cache environment memory
   logic [31:0] cmem [logic [31:0]];

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Cache model: checks each new access against the scoreboard, answers after the queued latency
   logic in_acc = 1'b0;
   logic err_seen = 1'b0;
   int   k = 0;
   int   cur_lat = 0;
   acc_t exp_acc;
   always @(negedge clk) begin
      cache_ready = 1'b0;
      cache_rd    = $urandom;
      if (!reset) begin
         in_acc   = 1'b0;
         err_seen = 1'b0;
      end else if (cache_re || cache_we) begin
         if (!in_acc) begin
            in_acc = 1'b1;
            k = 0;
            acc_count++;
            cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
            if (acc_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_access: got addr %h required none", cache_addr);
            end else begin
               exp_acc = acc_q.pop_front();
               check("cache_re", 64'(cache_re), 64'(!exp_acc.we));
               check("cache_we", 64'(cache_we), 64'(exp_acc.we));
               check("cache_addr", 64'(cache_addr), 64'(exp_acc.addr));
               if (exp_acc.we) check("cache_wd", 64'(cache_wd), 64'(exp_acc.wd));
            end
         end
         k++;
         check("err_timeout_wait", 64'(err_timeout), 64'(err_seen || (k - 1 >= TIMEOUT)));
         if (k - 1 >= TIMEOUT) err_seen = 1'b1;
         if (k > cur_lat) begin
            cache_ready = 1'b1;
            if (cache_we) cmem[cache_addr] = cache_wd;
            else cache_rd = cmem.exists(cache_addr) ? cmem[cache_addr] : init_val(cache_addr);
            in_acc = 1'b0;
         end
      end
   end

   // Monitor: idle cycles must be quiet; a completed group is checked against the scoreboard
   res_t got_res;
   always @(negedge clk) begin
      if (reset) begin
         if (!req_0 && !req_1) begin
            check("idle_stall", 64'(pipe_stall), 64'(0));
            check("idle_strobe", 64'({cache_re, cache_we}), 64'(0));
         end else if (!pipe_stall) begin
            if (res_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got completion required none");
            end else begin
               got_res = res_q.pop_front();
               check("rdata_0", 64'(rdata_0), 64'(got_res.r0));
               check("rdata_1", 64'(rdata_1), 64'(got_res.r1));
               check("dual_cnt", 64'(dual_cnt), 64'(got_res.dual));
               check("err_timeout", 64'(err_timeout), 64'(got_res.err));
            end
         end
      end
   end

   // Drive one group and push what the specification says must happen
   task automatic issue(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input int l0, input int l1);
      req_0 = r0; we_0 = w0; addr_0 = a0; wdata_0 = d0;
      req_1 = r1; we_1 = w1; addr_1 = a1; wdata_1 = d1;
      if (r0) begin
         acc_q.push_back('{we: w0, addr: a0, wd: d0});
         lat_q.push_back(l0);
         if (w0) ref_mem[a0] = d0;
         else ref_r0 = ref_rd(a0);
         if (l0 >= TIMEOUT) ref_err = 1'b1;
      end
      if (r1) begin
         acc_q.push_back('{we: w1, addr: a1, wd: d1});
         lat_q.push_back(l1);
         if (w1) ref_mem[a1] = d1;
         else ref_r1 = ref_rd(a1);
         if (l1 >= TIMEOUT) ref_err = 1'b1;
      end
      if (r0 && r1 && ref_dual < (1 << CNT_W) - 1) ref_dual++;
      if (r0 || r1) res_q.push_back('{r0: ref_r0, r1: ref_r1, dual: CNT_W'(ref_dual), err: ref_err});
      group_no++;
      $display("group %0d: lane0 req=%0d we=%0d addr=%h | lane1 req=%0d we=%0d addr=%h | lat %0d/%0d",
               group_no, r0, w0, a0, r1, w1, a1, l0, l1);
   endtask

   // Wait for the group to finish and check how long the pipeline was frozen
   task automatic finish_group(input int exp_stall);
      int  n;
      bit  done;
      n = 0;
      done = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (pipe_stall) n++;
         else begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL group_timeout: got stall after %0d cycles required release", n);
      end else begin
         check("stall_cycles", 64'(n), 64'(exp_stall));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_group(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                            input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                            input int l0, input int l1);
      int exp_stall;
      issue(r0, w0, a0, d0, r1, w1, a1, d1, l0, l1);
      exp_stall = (r0 || r1) ? 1 : 0;
      if (r0) exp_stall += l0 + 1;
      if (r1) exp_stall += l1 + 1;
      finish_group(exp_stall);
   endtask

   task automatic random_group();
      logic [31:0] a0, a1;
      a0 = 32'h40 + 32'(4 * $urandom_range(0, 3));
      a1 = 32'h40 + 32'(4 * $urandom_range(0, 3));
      run_group(1'($urandom), 1'($urandom), a0, $urandom,
                1'($urandom), 1'($urandom), a1, $urandom,
                $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1));
   endtask

   initial begin
      int start;
      // Reset held for two edges with a pending lane 0 request
      reset = 1'b0;
      req_0 = 1'b1; we_0 = 1'b0; addr_0 = 32'h100;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      check("rst_strobe", 64'({cache_re, cache_we}), 64'(0));
      check("rst_addr", 64'(cache_addr), 64'(0));
      check("rst_rdata", 64'({rdata_0, rdata_1}), 64'(0));
      check("rst_flags", 64'({pipe_stall, err_timeout, dual_cnt}), 64'(0));
      req_0 = 1'b0; addr_0 = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      // Single read hit
      cmem[32'h100] = 32'hDEAD_BEEF;
      ref_mem[32'h100] = 32'hDEAD_BEEF;
      run_group(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      check("single_rdata_0", 64'(rdata_0), 64'(32'hDEAD_BEEF));

      // Store lane 0 then load lane 1 from the same address
      run_group(1, 1, 32'h40, 32'h1234, 1, 0, 32'h40, 0, 0, 0);
      check("dual_rdata_1", 64'(rdata_1), 64'(32'h1234));
      check("dual_cnt_one", 64'(dual_cnt), 64'(1));

      // Lane 1 only with a one-cycle miss
      run_group(0, 0, 0, 0, 1, 0, 32'h44, 0, 0, 1);
      check("lane1_rdata_0_kept", 64'(rdata_0), 64'(32'hDEAD_BEEF));

      // Randomised groups, latencies just below the watchdog limit
      for (int i = 0; i < 150; i++) random_group();

      // Access that outlives the watchdog, then completes
      run_group(1, 0, 32'h48, 0, 0, 0, 0, 0, 6, 0);
      check("timeout_sticky", 64'(err_timeout), 64'(1));
      for (int i = 0; i < 3; i++) random_group();

      // Reset while lane 1 is waiting for the cache
      issue(1, 1, 32'h4C, 32'hCAFE, 1, 0, 32'h4C, 0, 0, 30);
      start = acc_count;
      for (int c = 0; c < 50; c++) begin
         if (acc_count >= start + 2) break;
         @(negedge clk);
      end
      check("midrst_in_l1", 64'(acc_count - start), 64'(2));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      req_0 = 1'b0; req_1 = 1'b0;
      res_q.delete(); acc_q.delete(); lat_q.delete();
      ref_r0 = '0; ref_r1 = '0; ref_dual = 0; ref_err = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("midrst_strobe", 64'({cache_re, cache_we}), 64'(0));
      check("midrst_flags", 64'({pipe_stall, err_timeout, dual_cnt}), 64'(0));
      check("midrst_rdata", 64'({rdata_0, rdata_1}), 64'(0));
      @(posedge clk); #1;

      for (int i = 0; i < 4; i++) random_group();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no end of test required $finish");
      $fatal(1, "bench did not terminate");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single data-cache port between the two M-stage lanes of the dual-issue pipeline.
- Each M-stage group may carry zero, one or two memory ops. The block serialises them in program order: lane 0 first, then lane 1.
- It drives the cache request, captures read data per lane, and stalls the pipeline until the whole group is serviced.
- It replaces ad-hoc lane selection with an explicit FSM, a timeout watchdog and a dual-op counter.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max cycles an access may wait for cache_ready before err_timeout sets
- CNT_W, 16, width of the dual_cnt statistics counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_0  in  1  lane 0 has a memory op (read or write); held stable while pipe_stall=1
- we_0  in  1  lane 0 op is a write (1) or read (0)
- addr_0  in  AW  lane 0 address
- wdata_0  in  DW  lane 0 store data
- req_1, we_1, addr_1, wdata_1  in  1/1/AW/DW  lane 1 equivalents
- cache_re  out  1  cache read strobe
- cache_we  out  1  cache write strobe
- cache_addr  out  AW  cache address
- cache_wd  out  DW  cache write data
- cache_rd  in  DW  cache read data, valid when cache_ready=1
- cache_ready  in  1  one-cycle pulse: current access complete
- rdata_0  out  DW  registered lane 0 load result
- rdata_1  out  DW  registered lane 1 load result
- pipe_stall  out  1  freeze IF..M stage registers
- err_timeout  out  1  sticky: an access exceeded TIMEOUT
- dual_cnt  out  CNT_W  saturating count of groups with both lanes requesting

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE.
  - All cache_* outputs, rdata_0/1, err_timeout, dual_cnt, timer = 0.
  - Reset overrides everything, including mid-access. Any in-flight cache access is abandoned; the cache is reset separately.
- cache_re, cache_we, cache_addr and cache_wd are registers. They are loaded on entry to L0/L1 and cleared to 0 on exit.
- States:
  - IDLE
    - pipe_stall = req_0|req_1 (combinational).
    - req_0 -> L0, load lane 0 request.
    - else req_1 -> L1, load lane 1 request.
    - else stay.
    - On leaving with req_0&req_1, dual_cnt increments, saturating at all-ones.
  - L0
    - pipe_stall=1; strobes held.
    - On cache_ready: if !we_0, rdata_0<=cache_rd. Then req_1 -> L1 (load lane 1 request) else -> DONE.
  - L1
    - pipe_stall=1.
    - On cache_ready: if !we_1, rdata_1<=cache_rd; -> DONE.
  - DONE
    - pipe_stall=0 for exactly this cycle; the pipeline advances at this edge. -> IDLE.
    - Requests are ignored in DONE because they still belong to the finished group.
- Latency: single op with a same-cycle hit = 3 cycles (IDLE, L0, DONE). Dual op = 4 cycles minimum.
- Cycles with no memory op: pipe_stall=0 and no cache strobes.
- rdata_x is unchanged for writes and for lanes without a request. It holds until the next capture.
- Ordering: lane 0 always completes before lane 1 issues, so a store on lane 0 followed by a load on lane 1 to the same address returns the stored value.
- Watchdog:
  - timer clears on entry to L0/L1 and increments each cycle in L0/L1 without cache_ready.
  - When timer reaches TIMEOUT, err_timeout<=1 (sticky until reset). The FSM keeps waiting.
- Simultaneous events: cache_ready arriving in the same cycle as entry is impossible, because strobes are registered. A cache_ready in IDLE or DONE is ignored.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding localparams: IDLE=2'd0, L0=2'd1, L1=2'd2, DONE=2'd3;
  - the lane index constants.
- One natural sub-module, mem_req_mux: registered selection of the lane 0/1 request onto the cache_* outputs.
- FSM, watchdog and counter stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_0=1 -> all outputs 0, state IDLE, no cache strobe.
- Single read: req_0=1, we_0=0, addr_0=0x100, cache_ready on first L0 cycle, cache_rd=0xDEADBEEF.
  - pipe_stall=1,1,0.
  - rdata_0=0xDEADBEEF.
  - cache_re high one cycle with cache_addr=0x100.
- Dual op: lane 0 write addr 0x40 data 0x1234, lane 1 read addr 0x40, cache_ready returns 0x1234.
  - Write issues before read.
  - rdata_1=0x1234.
  - pipe_stall high 3 cycles.
  - dual_cnt=1.
- Lane 1 only: req_0=0, req_1=1, read with 2-cycle cache miss -> states IDLE,L1,L1,DONE; rdata_0 unchanged.
- Timeout: TIMEOUT=4, cache_ready withheld 6 cycles.
  - err_timeout rises after 4 L0 cycles and stays 1.
  - A later cache_ready completes the access normally.
- Mid-access reset: reset=0 during L1 -> next cycle state IDLE, strobes 0, err_timeout 0, dual_cnt 0.
